// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: maps dithered 16-pixel words to word addresses, queues them in a
// small FIFO and shares the single-port framebuffer RAM with the scan-out reader.
module fb_write_arbiter #(
   parameter int WIDTH          = 512,
   parameter int HEIGHT         = 342,
   parameter int WORDS_PER_LINE = 32,
   parameter int ADDR_BITS      = 14,
   parameter int FIFO_DEPTH     = 4,
   parameter int MAX_STARVE     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_valid,
   input  logic [15:0]          wr_bits,
   input  logic [11:0]          wr_xaddr,
   input  logic [11:0]          wr_yaddr,
   input  logic                 frame_strobe,
   input  logic                 rd_req,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic                 rd_grant,
   output logic                 rd_valid,
   output logic [15:0]          rd_data,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [15:0]          ram_wdata,
   output logic                 ram_we,
   input  logic [15:0]          ram_rdata,
   output logic                 overflow,
   output logic [7:0]           drop_count
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int STARVE_W = $clog2(MAX_STARVE + 1);

   localparam logic [11:0]          WIDTH_C      = 12'(WIDTH);
   localparam logic [11:0]          HEIGHT_C     = 12'(HEIGHT);
   localparam logic [ADDR_BITS-1:0] WPL_C        = ADDR_BITS'(WORDS_PER_LINE);
   localparam logic [STARVE_W-1:0]  STARVE_MAX_C = STARVE_W'(MAX_STARVE);
   localparam logic [PTR_W:0]       PTR_ONE_C    = {{PTR_W{1'b0}}, 1'b1};

   // Bit 0 drives rd_grant and bit 1 drives ram_we directly from the state register.
   typedef enum logic [1:0] {
      GNT_IDLE  = 2'b00,
      GNT_READ  = 2'b01,
      GNT_WRITE = 2'b10
   } grant_t;

   logic                 rst_meta_r;
   logic                 rst_sync_r;
   logic                 rst_n_s;

   logic                 in_range_s;
   logic                 range_drop_s;
   logic [ADDR_BITS-1:0] enq_addr_s;
   logic                 enq_valid_r;
   logic [ADDR_BITS-1:0] enq_addr_r;
   logic [15:0]          enq_bits_r;

   logic [ADDR_BITS-1:0] fifo_addr_r [FIFO_DEPTH];
   logic [15:0]          fifo_bits_r [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr_r;
   logic [PTR_W:0]       rd_ptr_r;
   logic                 empty_s;
   logic                 full_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 push_drop_s;
   logic [ADDR_BITS-1:0] head_addr_s;
   logic [15:0]          head_bits_s;

   grant_t               grant_s;
   grant_t               state_r;
   logic [STARVE_W-1:0]  starve_r;
   logic [ADDR_BITS-1:0] ram_addr_r;
   logic [15:0]          ram_wdata_r;

   logic                 rd_pend_r;
   logic                 rd_valid_r;
   logic [15:0]          rd_data_r;

   logic                 overflow_r;
   logic [7:0]           drop_count_r;
   logic [1:0]           drop_inc_s;
   logic [8:0]           drop_sum_s;

   // Reset release is synchronised to clk; assertion stays asynchronous.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_r <= 1'b0;
         rst_sync_r <= 1'b0;
      end else begin
         rst_meta_r <= 1'b1;
         rst_sync_r <= rst_meta_r;
      end
   end

   assign rst_n_s = rst_sync_r;

   always_comb begin
      in_range_s = (wr_yaddr < HEIGHT_C) && (wr_xaddr < WIDTH_C);
      enq_addr_s = ADDR_BITS'(wr_yaddr) * WPL_C + ADDR_BITS'(wr_xaddr[11:4]);
      if (wr_valid && !in_range_s) begin
         range_drop_s = 1'b1;
      end else begin
         range_drop_s = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         enq_valid_r <= 1'b0;
         enq_addr_r  <= {ADDR_BITS{1'b0}};
         enq_bits_r  <= 16'h0000;
      end else begin
         enq_valid_r <= wr_valid && in_range_s;
         if (wr_valid && in_range_s) begin
            enq_addr_r <= enq_addr_s;
            enq_bits_r <= wr_bits;
         end
      end
   end

   // Wrap bit distinguishes full from empty when the index bits match.
   always_comb begin
      empty_s     = (wr_ptr_r == rd_ptr_r);
      full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
      head_addr_s = fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
      head_bits_s = fifo_bits_r[rd_ptr_r[PTR_W-1:0]];
   end

   always_comb begin
      grant_s = GNT_IDLE;
      if (!empty_s && (starve_r == STARVE_MAX_C)) begin
         grant_s = GNT_WRITE;
      end else if (rd_req) begin
         grant_s = GNT_READ;
      end else if (!empty_s) begin
         grant_s = GNT_WRITE;
      end else begin
         grant_s = GNT_IDLE;
      end
   end

   // A pop in the same cycle frees the head slot, so a full FIFO can still take a push.
   always_comb begin
      pop_s       = (grant_s == GNT_WRITE);
      push_s      = enq_valid_r && (!full_s || pop_s);
      push_drop_s = enq_valid_r && full_s && !pop_s;
      drop_inc_s  = {1'b0, range_drop_s} + {1'b0, push_drop_s};
      drop_sum_s  = {1'b0, drop_count_r} + {7'b0000000, drop_inc_s};
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         wr_ptr_r <= {(PTR_W + 1){1'b0}};
         rd_ptr_r <= {(PTR_W + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= enq_addr_r;
         fifo_bits_r[wr_ptr_r[PTR_W-1:0]] <= enq_bits_r;
      end
   end

   // Start-of-frame clearing takes precedence over any drop in the same cycle.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         overflow_r   <= 1'b0;
         drop_count_r <= 8'h00;
      end else if (frame_strobe) begin
         overflow_r   <= 1'b0;
         drop_count_r <= 8'h00;
      end else begin
         if (push_drop_s) begin
            overflow_r <= 1'b1;
         end
         drop_count_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_r     <= GNT_IDLE;
         ram_addr_r  <= {ADDR_BITS{1'b0}};
         ram_wdata_r <= 16'h0000;
         starve_r    <= {STARVE_W{1'b0}};
      end else begin
         state_r <= grant_s;
         case (grant_s)
            GNT_READ: begin
               ram_addr_r <= rd_addr;
            end
            GNT_WRITE: begin
               ram_addr_r  <= head_addr_s;
               ram_wdata_r <= head_bits_s;
            end
            default: begin
               ram_addr_r <= ram_addr_r;
            end
         endcase
         if (empty_s || pop_s) begin
            starve_r <= {STARVE_W{1'b0}};
         end else if (starve_r < STARVE_MAX_C) begin
            starve_r <= starve_r + {{(STARVE_W - 1){1'b0}}, 1'b1};
         end
      end
   end

   // RAM returns data one cycle after the address, so capture lands two cycles after grant.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         rd_pend_r  <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= 16'h0000;
      end else begin
         rd_pend_r  <= state_r[0];
         rd_valid_r <= rd_pend_r;
         if (rd_pend_r) begin
            rd_data_r <= ram_rdata;
         end
      end
   end

   assign rd_grant   = state_r[0];
   assign ram_we     = state_r[1];
   assign ram_addr   = ram_addr_r;
   assign ram_wdata  = ram_wdata_r;
   assign rd_valid   = rd_valid_r;
   assign rd_data    = rd_data_r;
   assign overflow   = overflow_r;
   assign drop_count = drop_count_r;

endmodule
